// File: rtl/alu_seq_if.sv
// Request/response bundle between the EX stage (master) and the sequential ALU (slave).
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             zero;
  logic             ovf;
  logic             dz;
  logic             illegal;

  modport master (
    output in_valid, opcode, a, b,
    input  in_ready, out_valid, result, result_hi, zero, ovf, dz, illegal
  );

  modport slave (
    input  in_valid, opcode, a, b,
    output in_ready, out_valid, result, result_hi, zero, ovf, dz, illegal
  );
endinterface

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle logic/arith/shift ops plus iterative
// shift-add multiply and restoring unsigned divide (WIDTH cycles each).
module alu_seq #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input logic      clk,
  input logic      rst_n,
  alu_seq_if.slave bus
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOR  = 4'd5;
  localparam logic [3:0] OP_SLT  = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam logic [3:0] OP_DIVU = 4'd11;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state, state_nxt;
  logic [SHAMT_W-1:0] cnt;
  logic               op_div;
  logic [WIDTH-1:0]   a_r, b_r;
  logic [WIDTH-1:0]   work_hi, work_lo;

  logic               accept, is_long, last;
  logic [WIDTH-1:0]   add_res, sub_res;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   sc_res;
  logic               sc_ovf, sc_ill;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_sub;
  logic [WIDTH-1:0]   step_hi, step_lo;

  assign bus.in_ready = (state == IDLE);
  assign accept       = bus.in_valid && bus.in_ready;
  assign is_long      = accept && (bus.opcode == OP_MUL || bus.opcode == OP_DIVU);
  assign last         = (state == RUN) && (cnt == SHAMT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (is_long) state_nxt = RUN;
      RUN:     if (last)    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign add_res = bus.a + bus.b;
  assign sub_res = bus.a - bus.b;
  assign shamt   = bus.b[SHAMT_W-1:0];

  // Single-cycle result computed straight from the request so it can be registered on accept.
  always_comb begin
    sc_res = '0;
    sc_ovf = 1'b0;
    sc_ill = (bus.opcode >= 4'd12);
    case (bus.opcode)
      OP_ADD: begin
        sc_res = add_res;
        sc_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (add_res[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = sub_res;
        sc_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (sub_res[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_AND:  sc_res = bus.a & bus.b;
      OP_OR:   sc_res = bus.a | bus.b;
      OP_XOR:  sc_res = bus.a ^ bus.b;
      OP_NOR:  sc_res = ~(bus.a | bus.b);
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      OP_SLL:  sc_res = bus.a << shamt;
      OP_SRL:  sc_res = bus.a >> shamt;
      OP_SRA:  sc_res = $unsigned($signed(bus.a) >>> shamt);
      default: sc_res = '0;
    endcase
  end

  // work_hi:work_lo is the 2*WIDTH product accumulator for MUL, remainder:quotient for DIVU.
  assign mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, a_r} : '0);
  assign div_shift = {work_hi, work_lo[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, b_r});
  assign div_sub   = div_shift[WIDTH-1:0] - b_r;

  always_comb begin
    step_hi = mul_sum[WIDTH:1];
    step_lo = {mul_sum[0], work_lo[WIDTH-1:1]};
    if (op_div) begin
      step_hi = div_ge ? div_sub : div_shift[WIDTH-1:0];
      step_lo = {work_lo[WIDTH-2:0], div_ge};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt           <= '0;
      op_div        <= 1'b0;
      a_r           <= '0;
      b_r           <= '0;
      work_hi       <= '0;
      work_lo       <= '0;
      bus.out_valid <= 1'b0;
      bus.result    <= '0;
      bus.result_hi <= '0;
      bus.zero      <= 1'b0;
      bus.ovf       <= 1'b0;
      bus.dz        <= 1'b0;
      bus.illegal   <= 1'b0;
    end else begin
      bus.out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (is_long) begin
            cnt     <= '0;
            op_div  <= (bus.opcode == OP_DIVU);
            a_r     <= bus.a;
            b_r     <= bus.b;
            work_hi <= '0;
            work_lo <= (bus.opcode == OP_DIVU) ? bus.a : bus.b;
          end else if (accept) begin
            bus.out_valid <= 1'b1;
            bus.result    <= sc_res;
            bus.result_hi <= '0;
            bus.zero      <= (sc_res == '0);
            bus.ovf       <= sc_ovf;
            bus.dz        <= 1'b0;
            bus.illegal   <= sc_ill;
          end
        end
        RUN: begin
          work_hi <= step_hi;
          work_lo <= step_lo;
          cnt     <= cnt + 1'b1;
          if (last) begin
            cnt           <= '0;
            bus.out_valid <= 1'b1;
            bus.result    <= step_lo;
            bus.result_hi <= step_hi;
            bus.zero      <= (step_lo == '0);
            bus.ovf       <= 1'b0;
            bus.dz        <= op_div && (b_r == '0);
            bus.illegal   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq with hand-computed expected values.
module tb_alu_seq;

  localparam int W = 32;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLT  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam logic [3:0] OP_DIVU = 4'd11;

  localparam logic [31:0] VA = 32'd101010101;
  localparam logic [31:0] VB = 32'd11;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.in_valid = 1'b1;
    bus.opcode   = op;
    bus.a        = a;
    bus.b        = b;
  endtask

  // flags are {zero, ovf, dz, illegal}
  task automatic checkResult(input string tag, input logic [31:0] hi, input logic [31:0] res,
                             input logic [3:0] flags);
    checkOutput({tag, " out_valid"}, 64'(bus.out_valid), 64'd1);
    checkOutput({tag, " hi:result"}, {bus.result_hi, bus.result}, {hi, res});
    checkOutput({tag, " flags"}, 64'({bus.zero, bus.ovf, bus.dz, bus.illegal}), 64'(flags));
  endtask

  task automatic doSingle(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    applyStimulus(op, a, b);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Leaves the bench at the negedge where out_valid is seen (or the budget ran out).
  task automatic runLong(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    int lat;
    int busy_bad;
    @(negedge clk);
    applyStimulus(op, a, b);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat      = 0;
    busy_bad = 0;
    while (bus.out_valid !== 1'b1 && lat < 100) begin
      if (bus.in_ready !== 1'b0) busy_bad++;
      if (lat == 5) applyStimulus(OP_ADD, 32'd1, 32'd1);
      if (lat == 6) bus.in_valid = 1'b0;
      @(negedge clk);
      lat++;
    end
    bus.in_valid = 1'b0;
    checkOutput({tag, " latency"}, 64'(lat), 64'd32);
    checkOutput({tag, " ready low in RUN"}, 64'(busy_bad), 64'd0);
    checkOutput({tag, " ready back"}, 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] b2b_exp [9];
    int seen;

    b2b_exp = '{32'h06054AC0, 32'h06054AAA, 32'h00000001, 32'h06054ABF, 32'h06054ABE,
                32'hF9FAB540, 32'h00000000, 32'h2A55A800, 32'h0000C0A9};

    bus.in_valid = 1'b0;
    bus.opcode   = 4'd0;
    bus.a        = '0;
    bus.b        = '0;

    #2;
    checkOutput("reset in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("reset out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("reset hi:result", {bus.result_hi, bus.result}, 64'd0);
    checkOutput("reset flags", 64'({bus.zero, bus.ovf, bus.dz, bus.illegal}), 64'd0);
    #5 rst_n = 1'b1;

    $display("[TB] back-to-back opcodes 0..8");
    for (int i = 0; i <= 9; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checkOutput($sformatf("b2b op%0d out_valid", i - 1), 64'(bus.out_valid), 64'd1);
        checkOutput($sformatf("b2b op%0d result", i - 1), 64'(bus.result), 64'(b2b_exp[i-1]));
        checkOutput($sformatf("b2b op%0d in_ready", i - 1), 64'(bus.in_ready), 64'd1);
      end
      if (i < 9) applyStimulus(4'(i), VA, VB);
      else       bus.in_valid = 1'b0;
    end

    $display("[TB] single-cycle corner cases");
    doSingle(OP_ADD, 32'h7FFFFFFF, 32'd1);
    checkResult("add ovf", 32'd0, 32'h80000000, 4'b0100);
    doSingle(OP_SUB, 32'd5, 32'd5);
    checkResult("sub zero", 32'd0, 32'd0, 4'b1000);
    doSingle(OP_SLT, 32'hFFFFFFFF, 32'd1);
    checkResult("slt signed", 32'd0, 32'd1, 4'b0000);
    doSingle(OP_SRA, 32'h80000000, 32'h00000021);
    checkResult("sra shamt", 32'd0, 32'hC0000000, 4'b0000);
    doSingle(4'd13, 32'd5, 32'd3);
    checkResult("illegal 13", 32'd0, 32'd0, 4'b1001);

    $display("[TB] multiply");
    runLong("mul small", OP_MUL, VA, VB);
    checkResult("mul small", 32'd0, 32'd1111111111, 4'b0000);
    @(negedge clk);
    checkOutput("mul pulse single", 64'(bus.out_valid), 64'd0);
    checkOutput("mul result held", 64'(bus.result), 64'd1111111111);
    runLong("mul max", OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF);
    checkResult("mul max", 32'hFFFFFFFE, 32'h00000001, 4'b0000);

    $display("[TB] divide");
    runLong("divu", OP_DIVU, VA, VB);
    checkResult("divu", 32'd5, 32'd9182736, 4'b0000);
    applyStimulus(OP_ADD, 32'd2, 32'd3);
    @(negedge clk);
    bus.in_valid = 1'b0;
    checkResult("add after divu", 32'd0, 32'd5, 4'b0000);
    @(negedge clk);
    checkOutput("add after divu pulse", 64'(bus.out_valid), 64'd0);
    runLong("divu by zero", OP_DIVU, VA, 32'd0);
    checkResult("divu by zero", VA, 32'hFFFFFFFF, 4'b0010);

    $display("[TB] abort during RUN");
    @(negedge clk);
    applyStimulus(OP_MUL, 32'd7, 32'd9);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("abort out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("abort hi:result", {bus.result_hi, bus.result}, 64'd0);
    checkOutput("abort flags", 64'({bus.zero, bus.ovf, bus.dz, bus.illegal}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) seen++;
    end
    checkOutput("abort no completion", 64'(seen), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
